// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } div_state_t;

  localparam int unsigned CLKDIV_WIDTH       = 10;
  localparam int unsigned CLKDIV_DEFAULT_DIV = 500;
  localparam int unsigned CLKDIV_TICKCNT_W   = 16;

endpackage

// File: rtl/div_counter.sv
// Half-period counter: wraps at term_val, toggling lohi and pulsing tick on each wrap.
module div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = CLKDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] q,
  output logic             lohi,
  output logic             tick
);

  // clear has priority so stop/idle always parks the wave low at q=0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      lohi <= 1'b0;
      tick <= 1'b0;
    end else if (clear) begin
      q    <= '0;
      lohi <= 1'b0;
      tick <= 1'b0;
    end else if (en) begin
      if (q >= term_val) begin
        q    <= '0;
        lohi <= ~lohi;
        tick <= 1'b1;
      end else begin
        q    <= q + WIDTH'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// Start/stop/pause controller with glitch-free divide-ratio updates.
// Optional CLKDIV_TICKCNT_EN adds a saturating tick_cnt output.
module clock_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = CLKDIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable_n,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [WIDTH-1:0] q,
  output logic             lohi,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] div_active
`ifdef CLKDIV_TICKCNT_EN
  ,
  output logic [CLKDIV_TICKCNT_W-1:0] tick_cnt
`endif
);

  div_state_t       state, state_next;
  logic [WIDTH-1:0] shadow, shadow_next, div_active_next;
  logic [WIDTH-1:0] term_val;
  logic             cfg_err_next;
  logic             hs_c, zero_c, cnt_en_c, clear_c, wrap_c;

  assign hs_c     = cfg_valid & cfg_ready;
  assign zero_c   = (cfg_div == '0);
  assign term_val = div_active - WIDTH'(1);
  assign cnt_en_c = ~enable_n & (state != IDLE);
  assign clear_c  = (state == IDLE) | stop;
  assign wrap_c   = cnt_en_c & (q >= term_val);

  div_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_c),
    .en       (cnt_en_c),
    .term_val (term_val),
    .q        (q),
    .lohi     (lohi),
    .tick     (tick)
  );

  // next-state and register updates; a shadow commits only on a wrap or a stop
  always_comb begin
    state_next      = state;
    div_active_next = div_active;
    shadow_next     = shadow;
    cfg_err_next    = hs_c & zero_c;
    case (state)
      IDLE: begin
        if (hs_c && !zero_c) div_active_next = cfg_div;
        if (start && !stop)  state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
          if (hs_c && !zero_c) div_active_next = cfg_div;
        end else if (hs_c && !zero_c) begin
          shadow_next = cfg_div;
          state_next  = PEND;
        end
      end
      PEND: begin
        if (stop || wrap_c) begin
          div_active_next = shadow;
          state_next      = stop ? IDLE : RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_active <= WIDTH'(DEFAULT_DIV);
      shadow     <= '0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      div_active <= div_active_next;
      shadow     <= shadow_next;
      cfg_err    <= cfg_err_next;
      cfg_ready  <= (state_next != PEND);
      busy       <= (state_next != IDLE);
    end
  end

`ifdef CLKDIV_TICKCNT_EN
  // counts ticks since the last accepted start, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (state == IDLE && start && !stop) begin
      tick_cnt <= '0;
    end else if (tick && tick_cnt != {CLKDIV_TICKCNT_W{1'b1}}) begin
      tick_cnt <= tick_cnt + CLKDIV_TICKCNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
Programmable controller around a 10-bit free-running divide counter. It sequences start, stop and pause, and accepts divide-ratio updates over a valid/ready handshake. Updates arriving mid-run are applied glitch-free at the next terminal count. It produces the divided square wave (lohi), a one-cycle tick per half-period, and the live count q for the lab display and timing logic.

Parameters:
WIDTH, 10, counter and divide-value width
DEFAULT_DIV, 500, half-period (in clk cycles) loaded at reset; must be 1..2^WIDTH-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level-sampled; begin dividing from IDLE
stop  in  1  level-sampled; return to IDLE
enable_n  in  1  active-low count enable; high freezes q and lohi
cfg_valid  in  1  new divide value offered
cfg_div  in  WIDTH  requested half-period
cfg_ready  out  1  controller can accept cfg
cfg_err  out  1  one-cycle pulse: offered cfg_div==0 was rejected
q  out  WIDTH  current count
lohi  out  1  divided square wave
tick  out  1  one-cycle pulse on every lohi toggle
busy  out  1  state != IDLE
div_active  out  WIDTH  half-period currently in use

Behaviour:
- Reset (async, any time, mid-operation included): state=IDLE, q=0, lohi=0, tick=0, cfg_err=0, div_active=DEFAULT_DIV, shadow cleared, cfg_ready=1, busy=0.
- States:
  - IDLE: q=0, lohi=0. start -> RUN. Any cfg handshake writes div_active at the next edge.
  - RUN: counts when enable_n=0. cfg handshake -> store shadow, go to PEND.
  - PEND: counts like RUN. At the terminal edge, div_active<=shadow, then -> RUN.
- Counting rule (RUN/PEND, enable_n=0), per edge:
  - If q >= div_active-1: q<=0, lohi<=~lohi, tick<=1.
  - Else q<=q+1, tick<=0.
  - The >= compare is defensive only; div_active never changes mid-count.
- enable_n=1 in RUN/PEND: q, lohi and state hold; tick=0. A pending update stays pending.
- Timing: start sampled at edge k. q=1 after edge k+1. First lohi rise plus tick after edge k+div_active. lohi period = 2*div_active cycles.
- stop in RUN/PEND -> IDLE at the next edge. q=0, lohi=0, tick=0. A pending shadow is committed to div_active at that edge.
- start and stop asserted in the same cycle: stop wins. start while busy is ignored.
- cfg_ready = 1 in IDLE and RUN, 0 in PEND. A handshake is cfg_valid & cfg_ready.
- cfg_div==0: handshake completes, no register change, no state change, cfg_err=1 for one cycle.
- New div_active takes effect at the wrap that commits it. The first full half-period at the new rate starts at q=0, so there is never a runt pulse.

Optional Feature:
CLKDIV_TICKCNT_EN
- Defined: adds output tick_cnt [15:0], which counts tick pulses since the last accepted start. It saturates at 16'hFFFF, is cleared by reset and by start-from-IDLE, and holds in IDLE.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package clk_div_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, PEND} div_state_t
  - localparam CLKDIV_WIDTH=10, CLKDIV_DEFAULT_DIV=500
- Sub-module div_counter: holds q and lohi.
  - Inputs: clk, reset, clear, en, term_val.
  - Outputs: q, lohi, tick.
- clock_div_ctrl owns the FSM, handshake, shadow register and err pulse.

Test Plan:
1. Reset, start at edge k, enable_n=0, defaults -> q=1 after k+1; lohi=1 and tick=1 after k+500; lohi=0 after k+1000; period 1000.
2. In IDLE, cfg_div=4 with cfg_valid for 1 cycle -> div_active=4. start -> lohi toggles every 4 cycles, tick once per toggle.
3. Running at div=4, q=1, offer cfg_div=2 -> cfg_ready drops, busy=1. Wrap at q=3 commits 2; following half-periods are exactly 2 cycles; cfg_ready=1 again.
4. Running, hold enable_n=1 for 7 cycles -> q and lohi frozen, tick=0. Release -> counting resumes from the held q.
5. cfg_div=0 offered -> cfg_err pulses 1 cycle, div_active unchanged. start+stop in the same cycle from IDLE -> stays IDLE.
6. Assert reset asynchronously mid-RUN at q=3, div=10 -> outputs immediately q=0, lohi=0, busy=0, div_active=500. With CLKDIV_TICKCNT_EN, tick_cnt=0.
